namuru_accum_fetcher: RTL and testbench



---
 rtl/namuru_fetch_pkg.sv | 33 +++
 rtl/namuru_fetch_fifo.sv | 56 +++++
 rtl/namuru_accum_fetcher.sv | 201 ++++++++++++++++++++
 tb/tb_namuru_accum_fetcher.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/namuru_fetch_pkg.sv
// Shared constants for the correlator accumulation fetcher: register map, frame sizes, FSM encoding.
package namuru_fetch_pkg;

  localparam logic [7:0]  REG_STATUS    = 8'hE0;
  localparam logic [7:0]  REG_NEWDATA   = 8'hE1;
  localparam logic [7:0]  REG_ACC_FIRST = 8'h04;
  localparam logic [7:0]  REG_ACC_LAST  = 8'h0D;
  localparam logic [7:0]  REG_CLEAR     = 8'hE4;

  localparam int          FRAME_WORDS   = 12;
  localparam int          SHORT_WORDS   = 2;

  localparam logic [31:0] CLEAR_VALUE   = 32'h0000_0003;
  localparam logic [31:0] TIMEOUT_WORD  = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_REQ   = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_CLR_REQ  = 3'd3,
    ST_CLR_WAIT = 3'd4
  } fetch_state_e;

  // Read order: status, new_data, then the accumulator block 0x04..0x0D.
  function automatic logic [7:0] reg_index(input logic [3:0] idx);
    case (idx)
      4'd0:    return REG_STATUS;
      4'd1:    return REG_NEWDATA;
      default: return REG_ACC_FIRST + {4'b0000, idx} - 8'd2;
    endcase
  endfunction

endpackage

// File: rtl/namuru_fetch_fifo.sv
// First-word-fall-through synchronous FIFO holding {last, data} stream words, with occupancy count.
module namuru_fetch_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/namuru_accum_fetcher.sv
// Wishbone initiator that drains one correlator channel's results into a framed stream on accum_int.
// Optional ack timeout is enabled by defining NAMURU_FETCH_TIMEOUT_EN.
module namuru_accum_fetcher
  import namuru_fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        correlator_clk,
  input  logic        rstn,
  input  logic        accum_int,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  input  logic        wb_ack_i,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  overrun_cnt,
  output logic        err,
  output logic [2:0]  dbg_state_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < FRAME_WORDS || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1 ||
      int'(REG_ACC_LAST - REG_ACC_FIRST) + 3 != FRAME_WORDS) begin : g_bad_param
    $error("namuru_accum_fetcher: invalid parameterisation");
  end

  fetch_state_e state_q;
  logic [3:0]   idx_q;
  logic         accum_q;
  logic         pending_q, pending_d;
  logic [7:0]   overrun_q, overrun_d;
  logic [31:0]  wb_adr_q, wb_dat_q;
  logic [3:0]   wb_sel_q;
  logic         wb_cyc_q, wb_stb_q, wb_we_q;

  logic         rise, start, room, drop, last_rd, tmo_hit;
  logic         fifo_push, fifo_empty;
  logic [32:0]  fifo_wdata, fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [1:0]   ovr_inc;
  logic [8:0]   ovr_sum;

  // Handshake: a stream word transfers on a clock edge where out_valid and out_ready are both high;
  // out_valid never depends on out_ready, and data/last are stable while valid is held.

  assign rise    = accum_int & ~accum_q;
  assign room    = (fifo_count <= CW'(FIFO_DEPTH - FRAME_WORDS));
  assign start   = (state_q == ST_IDLE) & pending_q;
  assign drop    = start & ~room;
  assign last_rd = (idx_q == 4'(FRAME_WORDS - 1)) |
                   ((idx_q == 4'(SHORT_WORDS - 1)) & ~wb_dat_i[0]);

`ifdef NAMURU_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;
  logic          waiting;

  assign waiting = wb_cyc_q & ((state_q == ST_RD_WAIT) | (state_q == ST_CLR_WAIT));
  assign tmo_hit = waiting & ~wb_ack_i & (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge correlator_clk) begin
    if (!rstn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (waiting & ~wb_ack_i & ~tmo_hit) ? tmo_q + 1'b1 : '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // A read that times out still closes the frame so the consumer never sees a dangling partial frame.
  assign fifo_push  = (state_q == ST_RD_WAIT) & (wb_ack_i | tmo_hit);
  assign fifo_wdata = tmo_hit ? {1'b1, TIMEOUT_WORD} : {last_rd, wb_dat_i};

  assign ovr_inc = {1'b0, rise & pending_q} + {1'b0, drop};
  assign ovr_sum = {1'b0, overrun_q} + {7'b0, ovr_inc};

  always_comb begin
    pending_d = pending_q | rise;
    if (start) pending_d = 1'b0;
    overrun_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
  end

  always_ff @(posedge correlator_clk) begin
    if (!rstn) begin
      accum_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= '0;
    end else begin
      accum_q   <= accum_int;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge correlator_clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_sel_q <= '0;
      wb_cyc_q <= 1'b0;
      wb_stb_q <= 1'b0;
      wb_we_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q <= '0;
          if (pending_q) state_q <= room ? ST_RD_REQ : ST_CLR_REQ;
        end
        ST_RD_REQ: begin
          wb_cyc_q <= 1'b1;
          wb_stb_q <= 1'b1;
          wb_we_q  <= 1'b0;
          wb_sel_q <= 4'hF;
          wb_adr_q <= BASE_ADDR | {22'b0, reg_index(idx_q), 2'b00};
          state_q  <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (wb_ack_i | tmo_hit) begin
            wb_cyc_q <= 1'b0;
            wb_stb_q <= 1'b0;
            wb_sel_q <= 4'h0;
            if (tmo_hit | last_rd) begin
              state_q <= ST_CLR_REQ;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= ST_RD_REQ;
            end
          end
        end
        ST_CLR_REQ: begin
          wb_cyc_q <= 1'b1;
          wb_stb_q <= 1'b1;
          wb_we_q  <= 1'b1;
          wb_sel_q <= 4'hF;
          wb_adr_q <= BASE_ADDR | {22'b0, REG_CLEAR, 2'b00};
          wb_dat_q <= CLEAR_VALUE;
          state_q  <= ST_CLR_WAIT;
        end
        ST_CLR_WAIT: begin
          if (wb_ack_i | tmo_hit) begin
            wb_cyc_q <= 1'b0;
            wb_stb_q <= 1'b0;
            wb_we_q  <= 1'b0;
            wb_sel_q <= 4'h0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  namuru_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk_i       (correlator_clk),
    .rstn_i      (rstn),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (out_valid & out_ready),
    .pop_data_o  (fifo_rdata),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign wb_adr_o    = wb_adr_q;
  assign wb_dat_o    = wb_dat_q;
  assign wb_sel_o    = wb_sel_q;
  assign wb_cyc_o    = wb_cyc_q;
  assign wb_stb_o    = wb_stb_q;
  assign wb_we_o     = wb_we_q;
  assign out_valid   = ~fifo_empty;
  assign out_data    = fifo_rdata[31:0];
  assign out_last    = fifo_rdata[32];
  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_namuru_accum_fetcher.sv
// Directed bench for namuru_accum_fetcher: Wishbone slave model, stream monitor and scoreboards.
module tb_namuru_accum_fetcher;

  localparam logic [31:0] BASE = 32'h4000_0000;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  logic        correlator_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        accum_int = 1'b0;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic        wb_ack_i = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, out_last, busy, err;
  logic        out_ready = 1'b0;
  logic [7:0]  overrun_cnt;
  logic [2:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  txn_t        exp_txn_q[$];
  logic [31:0] newdata_val    = 32'h1;
  logic [31:0] never_ack_addr = 32'hFFFF_FFFF;
  int          slv_cnt = 0;
  txn_t        slv_got, slv_exp;
  logic [32:0] mon_exp;

  // Byte offsets of the twelve result registers, in read order.
  logic [31:0] rd_off [12] = '{32'h380, 32'h384, 32'h010, 32'h014, 32'h018, 32'h01C,
                               32'h020, 32'h024, 32'h028, 32'h02C, 32'h030, 32'h034};

  always #5 correlator_clk = ~correlator_clk;

  namuru_accum_fetcher #(
    .FIFO_DEPTH     (16),
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .correlator_clk (correlator_clk),
    .rstn           (rstn),
    .accum_int      (accum_int),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_sel_o       (wb_sel_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_ack_i       (wb_ack_i),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .busy           (busy),
    .overrun_cnt    (overrun_cnt),
    .err            (err),
    .dbg_state_o    (dbg_state_o)
  );

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_value(input logic [31:0] adr);
    return (adr == (BASE | 32'h384)) ? newdata_val : (32'hA000_0000 | adr);
  endfunction

  // Slave: read ack 3 cycles after stb rises, write ack 1 cycle after; logs each completed transfer.
  always @(negedge correlator_clk) begin
    if (!(wb_cyc_o && wb_stb_o)) begin
      wb_ack_i = 1'b0;
      slv_cnt  = 0;
    end else if (!wb_ack_i) begin
      slv_cnt++;
      if (slv_cnt >= (wb_we_o ? 1 : 3) && wb_adr_o != never_ack_addr) begin
        wb_ack_i = 1'b1;
        wb_dat_i = wb_we_o ? 32'h0 : rd_value(wb_adr_o);
        slv_got  = '{wb_we_o, wb_sel_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0};
        slv_exp  = (exp_txn_q.size() > 0) ? exp_txn_q.pop_front() : '1;
        check("wb_txn", 69'(slv_got), 69'(slv_exp));
      end
    end
  end

  always @(negedge correlator_clk) begin
    if (rstn && out_valid && out_ready) begin
      mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("stream_word", 69'({out_last, out_data}), 69'(mon_exp));
    end
  end

  task automatic expect_clear();
    exp_txn_q.push_back('{1'b1, 4'hF, BASE | 32'h390, 32'h3});
  endtask

  task automatic expect_frame(input int nrd, input logic [31:0] nd);
    for (int i = 0; i < nrd; i++) begin
      exp_txn_q.push_back('{1'b0, 4'hF, BASE | rd_off[i], 32'h0});
      exp_q.push_back({(i == nrd - 1), (i == 1) ? nd : (32'hA000_0000 | BASE | rd_off[i])});
    end
    expect_clear();
  endtask

  task automatic pulse_accum();
    accum_int = 1'b1;
    @(posedge correlator_clk); #1;
    accum_int = 1'b0;
    @(posedge correlator_clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge correlator_clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    repeat (3) @(posedge correlator_clk);
    #1;
    while (quiet < 3 && n < 2000) begin
      @(posedge correlator_clk); #1;
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check({tag, "_idle_reached"}, 69'(quiet >= 3), 69'(1));
  endtask

  task automatic wait_stb(input string tag, input logic [31:0] adr);
    int n = 0;
    while (!(wb_stb_o && wb_adr_o == adr) && n < 500) begin
      @(posedge correlator_clk); #1;
      n++;
    end
    check({tag, "_stb_seen"}, 69'(wb_stb_o && wb_adr_o == adr), 69'(1));
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_txn_left"},  69'(exp_txn_q.size()), 69'(0));
    check({tag, "_words_left"}, 69'(exp_q.size()), 69'(0));
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge correlator_clk);
    #1;
    check("rst_cyc", 69'(wb_cyc_o), 69'(0));
    check("rst_stb", 69'(wb_stb_o), 69'(0));
    check("rst_we",  69'(wb_we_o),  69'(0));
    check("rst_sel", 69'(wb_sel_o), 69'(0));
    check("rst_adr", 69'(wb_adr_o), 69'(0));
    check("rst_dat", 69'(wb_dat_o), 69'(0));
    check("rst_valid", 69'(out_valid), 69'(0));
    check("rst_busy", 69'(busy), 69'(0));
    check("rst_overrun", 69'(overrun_cnt), 69'(0));
    check("rst_err", 69'(err), 69'(0));
    rstn = 1'b1;

    // Full 12-word frame, then clear write.
    out_ready = 1'b1;
    newdata_val = 32'h1;
    expect_frame(12, 32'h1);
    pulse_accum();
    wait_idle("t1");
    check_drained("t1");

    // new_data bit0 clear (other bits set) gives a 2-word frame.
    newdata_val = 32'h2;
    expect_frame(2, 32'h2);
    pulse_accum();
    wait_idle("t2");
    check_drained("t2");
    check("t2_overrun", 69'(overrun_cnt), 69'(0));

    // FIFO holds 12 of 16: next event is dropped, only the clear write goes out.
    do_reset();
    newdata_val = 32'h1;
    out_ready = 1'b0;
    expect_frame(12, 32'h1);
    pulse_accum();
    wait_idle("t3a");
    check("t3_txn_left", 69'(exp_txn_q.size()), 69'(0));
    check("t3_valid_held", 69'(out_valid), 69'(1));
    check("t3_last_head", 69'(out_last), 69'(0));
    expect_clear();
    pulse_accum();
    wait_idle("t3b");
    check("t3_drop_txn_left", 69'(exp_txn_q.size()), 69'(0));
    check("t3_overrun", 69'(overrun_cnt), 69'(1));
    out_ready = 1'b1;
    repeat (20) @(posedge correlator_clk);
    #1;
    check("t3_words_left", 69'(exp_q.size()), 69'(0));
    check("t3_valid_empty", 69'(out_valid), 69'(0));

    // Events during a frame: second is serviced afterwards, third merges as an overrun.
    do_reset();
    expect_frame(12, 32'h1);
    expect_frame(12, 32'h1);
    pulse_accum();
    wait_stb("t4", BASE | 32'h380);
    pulse_accum();
    check("t4_overrun_after_2nd", 69'(overrun_cnt), 69'(0));
    repeat (2) @(posedge correlator_clk);
    #1;
    pulse_accum();
    check("t4_overrun_after_3rd", 69'(overrun_cnt), 69'(1));
    wait_idle("t4");
    check_drained("t4");
    check("t4_overrun_end", 69'(overrun_cnt), 69'(1));

    // Reset while waiting on the idx 5 read, then a clean frame.
    expect_frame(12, 32'h1);
    pulse_accum();
    wait_stb("t5", BASE | 32'h01C);
    rstn = 1'b0;
    @(posedge correlator_clk); #1;
    check("t5_cyc", 69'(wb_cyc_o), 69'(0));
    check("t5_stb", 69'(wb_stb_o), 69'(0));
    check("t5_valid", 69'(out_valid), 69'(0));
    check("t5_overrun", 69'(overrun_cnt), 69'(0));
    check("t5_busy", 69'(busy), 69'(0));
    rstn = 1'b1;
    exp_q.delete();
    exp_txn_q.delete();
    expect_frame(12, 32'h1);
    pulse_accum();
    wait_idle("t5b");
    check_drained("t5b");

`ifdef NAMURU_FETCH_TIMEOUT_EN
    // Slave never answers 0x18: DEADBEEF closes the frame and the clear still goes out.
    never_ack_addr = BASE | 32'h018;
    for (int i = 0; i < 4; i++) begin
      exp_txn_q.push_back('{1'b0, 4'hF, BASE | rd_off[i], 32'h0});
      exp_q.push_back({1'b0, (i == 1) ? 32'h1 : (32'hA000_0000 | BASE | rd_off[i])});
    end
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    expect_clear();
    pulse_accum();
    wait_idle("t6");
    check_drained("t6");
    check("t6_err", 69'(err), 69'(1));
    never_ack_addr = 32'hFFFF_FFFF;
`else
    check("err_tied_low", 69'(err), 69'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
